// File: rtl/uart_boot_loader.sv
// -----------------------------------------------------------------------------
// uart_boot_loader
//
// Receives a program image over an 8N1 UART line and writes it word by word
// into instruction memory. The processor is held in reset until a complete,
// checksum-valid image has been written, then released to fetch from word 0.
//
// Frame: 0xA5 | N lo | N hi | N x 4 data bytes (little-endian words) | XOR csum
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   uart_rx_i     asynchronous serial input, idle high
//   o_imem_wren   one-cycle instruction-memory write strobe
//   o_imem_addr   word address of the write
//   o_imem_wdata  write data
//   o_core_rst_n  active-low reset to the processor
//   o_busy        high while a frame is being received (LEN_LO..CSUM)
//   o_done        high after a valid image has been loaded
//   o_err         sticky error flag, cleared by the next sync byte
//
// Build option:
//   BOOT_RELOAD_EN  when defined, a sync byte received in DONE starts a new
//                   load without rst_i. When undefined, DONE is terminal.
// -----------------------------------------------------------------------------
module uart_boot_loader #(
   parameter int unsigned CLK_FREQ_HZ = 50000000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned IMEM_ADDR_W = 13
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   uart_rx_i,
   output logic                   o_imem_wren,
   output logic [IMEM_ADDR_W-1:0] o_imem_addr,
   output logic [31:0]            o_imem_wdata,
   output logic                   o_core_rst_n,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err
);

   // CLKS_PER_BIT must be at least 4 for the mid-bit sampling to work.
   localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0]       SYNC_BYTE = 8'hA5;
   localparam int unsigned      MAX_WORDS = 2 ** IMEM_ADDR_W;

   // ---------------------------------------------------------------------------
   // UART receiver
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   rx_state_e        rx_state_q;
   logic             rx_meta_q;
   logic             rx_sync_q;
   logic             rx_prev_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [2:0]       rx_bit_q;
   logic [7:0]       rx_shift_q;   // holds the received byte while byte_valid_q is high
   logic             byte_valid_q;
   logic             frame_err_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // always_ff reads the pre-edge value of every register regardless of order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // Synchronizer flops reset to the idle line level so reset release
         // never looks like a falling edge.
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_meta_q    <= uart_rx_i;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;

         case (rx_state_q)
            RX_IDLE: begin
               // Edge-triggered start so a line held low after a framing
               // error does not restart the receiver repeatedly.
               if (rx_prev_q && !rx_sync_q) begin
                  rx_state_q <= RX_START;
                  rx_cnt_q   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt_q == HALF_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                  rx_bit_q   <= rx_bit_q + 1'b1;
                  if (rx_bit_q == 3'd7) begin
                     rx_state_q <= RX_STOP;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q     <= '0;
                  rx_state_q   <= RX_IDLE;
                  byte_valid_q <= rx_sync_q;
                  frame_err_q  <= !rx_sync_q;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Frame parser
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_e;

   state_e               state_q;
   logic [15:0]          len_q;
   logic [IMEM_ADDR_W:0] word_idx_q;   // one extra bit so N = 2**IMEM_ADDR_W does not wrap
   logic [1:0]           byte_idx_q;
   logic [23:0]          word_q;       // first three bytes of the word in progress
   logic [7:0]           csum_q;
   logic                 wren_q;
   logic [IMEM_ADDR_W-1:0] addr_q;
   logic [31:0]          wdata_q;
   logic                 core_rst_n_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;

   logic [15:0]          len_d;
   logic [31:0]          word_d;
   logic [IMEM_ADDR_W:0] word_idx_d;
   logic                 sync_state;
   logic                 sync_accept;

   // NOTE: every always_comb output is assigned on every path, so no latches.
   always_comb begin
      len_d      = {rx_shift_q, len_q[7:0]};
      word_d     = {rx_shift_q, word_q};
      word_idx_d = word_idx_q + 1'b1;
      sync_state = (state_q == ST_IDLE) || (state_q == ST_ERR);
`ifdef BOOT_RELOAD_EN
      sync_state = sync_state || (state_q == ST_DONE);
`endif
      sync_accept = byte_valid_q && (rx_shift_q == SYNC_BYTE) && sync_state;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         word_idx_q   <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         csum_q       <= '0;
         wren_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         wren_q       <= 1'b0;
         // Core release lags entry into DONE by one cycle.
         core_rst_n_q <= (state_q == ST_DONE);

         // A framing error in DONE is ignored so a running core is never
         // pulled back into reset by line noise.
         if (frame_err_q && (state_q != ST_DONE)) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
         end else if (sync_accept) begin
            state_q      <= ST_LEN_LO;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            core_rst_n_q <= 1'b0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
         end else if (byte_valid_q) begin
            case (state_q)
               ST_LEN_LO: begin
                  len_q[7:0] <= rx_shift_q;
                  state_q    <= ST_LEN_HI;
               end
               ST_LEN_HI: begin
                  len_q <= len_d;
                  if (32'(len_d) > MAX_WORDS) begin
                     state_q <= ST_ERR;
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end else if (len_d == 16'd0) begin
                     state_q <= ST_CSUM;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  word_q     <= word_d[31:8];
                  csum_q     <= csum_q ^ rx_shift_q;
                  byte_idx_q <= byte_idx_q + 1'b1;
                  if (byte_idx_q == 2'd3) begin
                     wren_q     <= 1'b1;
                     addr_q     <= word_idx_q[IMEM_ADDR_W-1:0];
                     wdata_q    <= word_d;
                     word_idx_q <= word_idx_d;
                     if (32'(word_idx_d) == 32'(len_q)) begin
                        state_q <= ST_CSUM;
                     end
                  end
               end
               ST_CSUM: begin
                  busy_q <= 1'b0;
                  if (rx_shift_q == csum_q) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_ERR;
                     err_q   <= 1'b1;
                  end
               end
               default: ;  // IDLE, DONE, ERR: non-sync bytes are ignored
            endcase
         end
      end
   end

   assign o_imem_wren  = wren_q;
   assign o_imem_addr  = addr_q;
   assign o_imem_wdata = wdata_q;
   assign o_core_rst_n = core_rst_n_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_err        = err_q;

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Upstream of the processor top: receives a program image over a UART serial line and writes it word-by-word into instruction memory.
- Holds the core in reset through its active-low core-reset output, which drives the processor's rst_n, until a complete, checksum-valid image has been written.
- After a good load, releases the core so it starts fetching from word address 0.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division, must be >= 4).
- IMEM_ADDR_W, 13, instruction-memory word-address width; maximum image is 2**IMEM_ADDR_W words.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- uart_rx_i  input  1  asynchronous serial input, idle high, 8N1.
- o_imem_wren  output  1  one-cycle instruction-memory write strobe.
- o_imem_addr  output  IMEM_ADDR_W  word address of the write.
- o_imem_wdata  output  32  write data.
- o_core_rst_n  output  1  active-low reset to the processor.
- o_busy  output  1  high while a frame is in progress (LEN_LO through CSUM).
- o_done  output  1  high after a valid image is loaded.
- o_err  output  1  sticky error flag; cleared by the next sync byte or rst_i.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: o_imem_wren=0, o_imem_addr=0, o_imem_wdata=0, o_core_rst_n=0, o_busy=0, o_done=0, o_err=0, FSM=IDLE, RX=idle.
- Reset is sampled every cycle, including mid-byte or mid-frame. Asserting it aborts everything and returns all state to the values above.

RX path:
- uart_rx_i passes through a 2-flop synchronizer.
- A falling edge in RX idle starts a byte. The start bit is re-checked at CLKS_PER_BIT/2; if it reads high, the byte is a glitch and RX returns to idle.
- Data bits are sampled every CLKS_PER_BIT cycles, LSB first, then the stop bit.
- Stop bit = 1: byte_valid pulses for 1 cycle.
- Stop bit = 0: the byte is discarded, o_err is set, and the FSM goes to ERR.

Frame format:
- Sync byte 0xA5.
- Word count N, 16-bit little-endian (LEN_LO, then LEN_HI).
- N x 4 data bytes, each word little-endian.
- 1 checksum byte = XOR of all data bytes. It is 0x00 when N=0.

FSM states and transitions:
- IDLE: bytes other than 0xA5 are ignored. On 0xA5: clear o_err, clear the word index and checksum accumulator, go to LEN_LO.
- LEN_LO: store the low count byte, go to LEN_HI.
- LEN_HI: store the high count byte.
  - N > 2**IMEM_ADDR_W: go to ERR.
  - N = 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: shift each byte into bits [8k+7:8k], k = 0..3, and XOR it into the accumulator. After byte k=3:
  - o_imem_wren=1 for exactly one cycle, o_imem_addr = word index, o_imem_wdata = assembled word.
  - Increment the word index.
  - Go to CSUM when the index reaches N.
- CSUM: byte equals the accumulator: go to DONE. Mismatch: go to ERR.
- DONE: o_done=1, and o_core_rst_n=1 from the cycle after the transition. Received bytes are ignored unless BOOT_RELOAD_EN is defined.
- ERR: o_err=1, o_core_rst_n stays 0. A 0xA5 byte goes to LEN_LO, as from IDLE; other bytes are ignored. Memory words already written are not rolled back.

Other rules:
- o_core_rst_n is 0 in every state except DONE.
- Latency: the write strobe occurs 1 cycle after the byte_valid of the 4th byte of a word. The last write precedes the checksum byte, so it always precedes core release.
- The word index is IMEM_ADDR_W+1 bits wide, so N = 2**IMEM_ADDR_W is accepted without wrap. o_imem_addr is its low IMEM_ADDR_W bits.

Optional Feature:
- Macro: BOOT_RELOAD_EN.
- Defined: in DONE, a 0xA5 byte deasserts o_core_rst_n and o_done on the next cycle and enters LEN_LO, allowing an in-field reload without rst_i.
- Undefined: DONE is terminal until rst_i; all bytes are ignored.

Test Plan:
All tests use CLK_FREQ_HZ=1000000, BAUD_RATE=100000 (10 clks/bit), IMEM_ADDR_W=4.
1. Send A5 02 00 | 13 00 00 00 | B3 00 10 00 | csum 0xB0 -> wren pulses: addr0=0x00000013, addr1=0x001000B3; o_done=1; o_core_rst_n rises after the checksum byte; o_err=0.
2. Same frame with csum 0x00 -> both writes occur; FSM in ERR, o_err=1, o_core_rst_n=0. Then resend the valid frame -> o_err clears on A5, ends in DONE.
3. Send A5 11 00 (N=17 > 16) -> ERR after LEN_HI, no wren ever. Also send A5 00 00 00 -> DONE with no writes.
4. Send a byte with stop bit 0, and a 3-clock low glitch on uart_rx_i -> framing byte sets o_err; the glitch produces no byte_valid.
5. Assert rst_i during the 2nd data byte of case 1 -> all outputs return to reset values next edge. Then send a full frame -> normal load.
6. After DONE, send A5 01 00 FF FF FF FF 00 -> with BOOT_RELOAD_EN: core reset reasserts, addr0=0xFFFFFFFF, DONE again. Without it: no change, no wren.
